// File: rtl/fifo_sync.sv
// Single-clock FIFO with selectable standard/first-word-fall-through read,
// programmable almost-full/almost-empty levels, sticky error flags and a synchronous flush.
module fifo_sync #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WORDS_TOTAL = 2**ADDR_W,
    parameter int FWFT        = 0,
    parameter int AFULL_THR   = WORDS_TOTAL - 2,
    parameter int AEMPTY_THR  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wen,
    output logic              wfull,
    output logic              walmost_full,
    output logic [DATA_W-1:0] rdata,
    input  logic              ren,
    output logic              rvalid,
    output logic              rempty,
    output logic              ralmost_empty,
    output logic [ADDR_W:0]   load,
    output logic              overflow,
    output logic              underflow
);

    localparam int LW = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_TOTAL - 1);
    localparam logic [LW-1:0]     DEPTH     = LW'(WORDS_TOTAL);
    localparam logic [LW-1:0]     AFULL_L   = LW'(AFULL_THR);
    localparam logic [LW-1:0]     AEMPTY_L  = LW'(AEMPTY_THR);
    localparam logic              FWFT_MODE = (FWFT != 0);

    logic [DATA_W-1:0] mem [WORDS_TOTAL];

    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [LW-1:0]     load_q, load_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q, rvalid_d;
    logic              rempty_q, rempty_d;
    logic              wfull_q, wfull_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr, rd, fetch, memHasWord;

    // In FWFT mode the word sitting in the output register is part of load but
    // no longer in memory, so the memory occupancy is load minus rvalid.
    always_comb begin
        wr         = wen & ~wfull_q & ~clr;
        rd         = ren & ~rempty_q & ~clr;
        memHasWord = (load_q != {{ADDR_W{1'b0}}, rvalid_q & FWFT_MODE});
        load_d     = load_q + {{ADDR_W{1'b0}}, wr} - {{ADDR_W{1'b0}}, rd};

        if (FWFT_MODE) begin
            fetch    = ~clr & memHasWord & (~rvalid_q | rd);
            rvalid_d = fetch | (rvalid_q & ~rd);
            rempty_d = ~rvalid_d;
        end else begin
            fetch    = rd & memHasWord;
            rvalid_d = fetch;
            rempty_d = (load_d == '0);
        end

        waddr_d = waddr_q;
        if (wr) waddr_d = (waddr_q == LAST_ADDR) ? '0 : waddr_q + 1'b1;
        raddr_d = raddr_q;
        if (fetch) raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + 1'b1;

        wfull_d     = (load_d == DEPTH);
        afull_d     = (load_d >= AFULL_L);
        aempty_d    = (load_d <= AEMPTY_L);
        overflow_d  = overflow_q | (wen & wfull_q & ~clr);
        underflow_d = underflow_q | (ren & rempty_q & ~clr);

        if (clr) begin
            waddr_d     = '0;
            raddr_d     = '0;
            load_d      = '0;
            rvalid_d    = 1'b0;
            rempty_d    = 1'b1;
            wfull_d     = 1'b0;
            afull_d     = 1'b0;
            aempty_d    = 1'b1;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[waddr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q     <= '0;
            raddr_q     <= '0;
            load_q      <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            rempty_q    <= 1'b1;
            wfull_q     <= 1'b0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            load_q      <= load_d;
            rvalid_q    <= rvalid_d;
            rempty_q    <= rempty_d;
            wfull_q     <= wfull_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (clr) begin
                rdata_q <= '0;
            end else if (fetch) begin
                rdata_q <= mem[raddr_q];
            end
        end
    end

    assign wfull         = wfull_q;
    assign walmost_full  = afull_q;
    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = aempty_q;
    assign load          = load_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: standard-mode 16-deep, FWFT 16-deep and
// standard-mode 12-deep instances share one clock and reset.
module tb_fifo_sync;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errCount = 0;
    int   checkCount = 0;

    always #5 clk = ~clk;

    // standard-mode instance
    logic       sClr = 0, sWen = 0, sRen = 0;
    logic [7:0] sWdata = 0, sRdata;
    logic       sWfull, sAfull, sRvalid, sRempty, sAempty, sOverflow, sUnderflow;
    logic [4:0] sLoad;

    // FWFT instance
    logic       fClr = 0, fWen = 0, fRen = 0;
    logic [7:0] fWdata = 0, fRdata;
    logic       fWfull, fAfull, fRvalid, fRempty, fAempty, fOverflow, fUnderflow;
    logic [4:0] fLoad;

    // 12-word standard-mode instance
    logic       wClr = 0, wWen = 0, wRen = 0;
    logic [7:0] wWdata = 0, wRdata;
    logic       wWfull, wAfull, wRvalid, wRempty, wAempty, wOverflow, wUnderflow;
    logic [4:0] wLoad;

    fifo_sync dutStd (
        .clk(clk), .rst_n(rst_n), .clr(sClr), .wdata(sWdata), .wen(sWen),
        .wfull(sWfull), .walmost_full(sAfull), .rdata(sRdata), .ren(sRen),
        .rvalid(sRvalid), .rempty(sRempty), .ralmost_empty(sAempty),
        .load(sLoad), .overflow(sOverflow), .underflow(sUnderflow)
    );

    fifo_sync #(.FWFT(1)) dutFwft (
        .clk(clk), .rst_n(rst_n), .clr(fClr), .wdata(fWdata), .wen(fWen),
        .wfull(fWfull), .walmost_full(fAfull), .rdata(fRdata), .ren(fRen),
        .rvalid(fRvalid), .rempty(fRempty), .ralmost_empty(fAempty),
        .load(fLoad), .overflow(fOverflow), .underflow(fUnderflow)
    );

    fifo_sync #(.ADDR_W(4), .WORDS_TOTAL(12)) dutW12 (
        .clk(clk), .rst_n(rst_n), .clr(wClr), .wdata(wWdata), .wen(wWen),
        .wfull(wWfull), .walmost_full(wAfull), .rdata(wRdata), .ren(wRen),
        .rvalid(wRvalid), .rempty(wRempty), .ralmost_empty(wAempty),
        .load(wLoad), .overflow(wOverflow), .underflow(wUnderflow)
    );

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checkCount++; if (sLoad !== 5'd0) begin errCount++; $display("[TB] FAIL reset_load: got %0d want 0", sLoad); end
        checkCount++; if ({sRempty, sAempty, sWfull, sAfull} !== 4'b1100) begin errCount++; $display("[TB] FAIL reset_flags: got %b want 1100", {sRempty, sAempty, sWfull, sAfull}); end
        checkCount++; if ({sRvalid, sOverflow, sUnderflow} !== 3'b000) begin errCount++; $display("[TB] FAIL reset_status: got %b want 000", {sRvalid, sOverflow, sUnderflow}); end
        checkCount++; if (sRdata !== 8'h00) begin errCount++; $display("[TB] FAIL reset_rdata: got %h want 00", sRdata); end
        checkCount++; if ({fRempty, fRvalid, fLoad} !== {2'b10, 5'd0}) begin errCount++; $display("[TB] FAIL reset_fwft: got %b want 1000000", {fRempty, fRvalid, fLoad}); end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            sWen = 1; sWdata = 8'(i);
            tick();
            checkCount++; if (sLoad !== 5'(i)) begin errCount++; $display("[TB] FAIL fill_load: got %0d want %0d", sLoad, i); end
            checkCount++; if (sAfull !== (i >= 14)) begin errCount++; $display("[TB] FAIL fill_afull: load %0d got %b want %b", i, sAfull, (i >= 14)); end
            checkCount++; if (sWfull !== (i == 16)) begin errCount++; $display("[TB] FAIL fill_wfull: load %0d got %b want %b", i, sWfull, (i == 16)); end
        end
        sWdata = 8'hFF;
        tick();
        sWen = 0;
        checkCount++; if (sOverflow !== 1'b1) begin errCount++; $display("[TB] FAIL fill_overflow: got %b want 1", sOverflow); end
        checkCount++; if (sLoad !== 5'd16) begin errCount++; $display("[TB] FAIL fill_load_after_ovf: got %0d want 16", sLoad); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            sRen = 1;
            tick();
            checkCount++; if (sRvalid !== 1'b1) begin errCount++; $display("[TB] FAIL drain_rvalid: read %0d got %b want 1", i, sRvalid); end
            checkCount++; if (sRdata !== 8'(i)) begin errCount++; $display("[TB] FAIL drain_rdata: got %h want %h", sRdata, 8'(i)); end
            checkCount++; if (sLoad !== 5'(16 - i)) begin errCount++; $display("[TB] FAIL drain_load: got %0d want %0d", sLoad, 16 - i); end
            checkCount++; if (sAempty !== ((16 - i) <= 2)) begin errCount++; $display("[TB] FAIL drain_aempty: load %0d got %b", 16 - i, sAempty); end
        end
        sRen = 0;
        tick();
        checkCount++; if (sRvalid !== 1'b0) begin errCount++; $display("[TB] FAIL drain_rvalid_pulse: got %b want 0", sRvalid); end
        checkCount++; if ({sRempty, sAempty, sUnderflow, sOverflow} !== 4'b1101) begin errCount++; $display("[TB] FAIL drain_flags: got %b want 1101", {sRempty, sAempty, sUnderflow, sOverflow}); end
    endtask

    task automatic test_simultaneous();
        sClr = 1;
        tick();
        sClr = 0;
        checkCount++; if (sOverflow !== 1'b0) begin errCount++; $display("[TB] FAIL clr_overflow: got %b want 0", sOverflow); end
        // empty: write wins, read is dropped and flagged
        sWen = 1; sRen = 1; sWdata = 8'h33;
        tick();
        sRen = 0;
        checkCount++; if (sLoad !== 5'd1) begin errCount++; $display("[TB] FAIL simul_empty_load: got %0d want 1", sLoad); end
        checkCount++; if ({sUnderflow, sRvalid} !== 2'b10) begin errCount++; $display("[TB] FAIL simul_empty_flags: got %b want 10", {sUnderflow, sRvalid}); end
        for (int i = 0; i < 4; i++) begin
            sWdata = 8'h34 + 8'(i);
            tick();
        end
        checkCount++; if (sLoad !== 5'd5) begin errCount++; $display("[TB] FAIL simul_prefill: got %0d want 5", sLoad); end
        sRen = 1; sWdata = 8'h38;
        tick();
        sRen = 0;
        checkCount++; if (sLoad !== 5'd5) begin errCount++; $display("[TB] FAIL simul_mid_load: got %0d want 5", sLoad); end
        checkCount++; if ({sRvalid, sRdata} !== {1'b1, 8'h33}) begin errCount++; $display("[TB] FAIL simul_mid_rdata: got %b/%h want 1/33", sRvalid, sRdata); end
        for (int i = 0; i < 11; i++) begin
            sWdata = 8'h40 + 8'(i);
            tick();
        end
        checkCount++; if ({sWfull, sLoad} !== {1'b1, 5'd16}) begin errCount++; $display("[TB] FAIL simul_full: got %b/%0d want 1/16", sWfull, sLoad); end
        // full: read wins, write is dropped and flagged
        sRen = 1; sWdata = 8'hEE;
        tick();
        sRen = 0; sWen = 0;
        checkCount++; if (sLoad !== 5'd15) begin errCount++; $display("[TB] FAIL simul_full_load: got %0d want 15", sLoad); end
        checkCount++; if ({sOverflow, sWfull, sRdata} !== {2'b10, 8'h34}) begin errCount++; $display("[TB] FAIL simul_full_flags: got %b/%b/%h want 1/0/34", sOverflow, sWfull, sRdata); end
    endtask

    task automatic test_clr();
        logic [7:0] expData [8] = '{8'h35, 8'h36, 8'h37, 8'h38, 8'h40, 8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 8; i++) begin
            sRen = 1;
            tick();
            checkCount++; if (sRdata !== expData[i]) begin errCount++; $display("[TB] FAIL clr_preread: got %h want %h", sRdata, expData[i]); end
        end
        sRen = 0;
        checkCount++; if ({sLoad, sOverflow, sUnderflow} !== {5'd7, 2'b11}) begin errCount++; $display("[TB] FAIL clr_before: got %0d/%b/%b want 7/1/1", sLoad, sOverflow, sUnderflow); end
        sClr = 1; sWen = 1; sWdata = 8'h99;
        tick();
        sClr = 0; sWen = 0;
        checkCount++; if (sLoad !== 5'd0) begin errCount++; $display("[TB] FAIL clr_load: got %0d want 0", sLoad); end
        checkCount++; if ({sRempty, sAempty, sWfull, sAfull, sOverflow, sUnderflow} !== 6'b110000) begin errCount++; $display("[TB] FAIL clr_flags: got %b want 110000", {sRempty, sAempty, sWfull, sAfull, sOverflow, sUnderflow}); end
        sWen = 1; sWdata = 8'h77;
        tick();
        sWen = 0; sRen = 1;
        tick();
        sRen = 0;
        checkCount++; if ({sRvalid, sRdata, sLoad} !== {1'b1, 8'h77, 5'd0}) begin errCount++; $display("[TB] FAIL clr_after: got %b/%h/%0d want 1/77/0", sRvalid, sRdata, sLoad); end
    endtask

    task automatic test_fwft();
        fWen = 1; fWdata = 8'hA5;
        tick();
        fWen = 0;
        checkCount++; if ({fRvalid, fRempty, fLoad} !== {2'b01, 5'd1}) begin errCount++; $display("[TB] FAIL fwft_after_write: got %b/%b/%0d want 0/1/1", fRvalid, fRempty, fLoad); end
        tick();
        checkCount++; if ({fRvalid, fRempty, fRdata} !== {2'b10, 8'hA5}) begin errCount++; $display("[TB] FAIL fwft_head: got %b/%b/%h want 1/0/a5", fRvalid, fRempty, fRdata); end
        fRen = 1;
        tick();
        fRen = 0;
        checkCount++; if ({fRvalid, fRempty, fLoad} !== {2'b01, 5'd0}) begin errCount++; $display("[TB] FAIL fwft_pop: got %b/%b/%0d want 0/1/0", fRvalid, fRempty, fLoad); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3] = '{8'hB1, 8'hB2, 8'hB3};
        for (int i = 0; i < 3; i++) begin
            fWen = 1; fWdata = words[i];
            tick();
        end
        fWen = 0;
        checkCount++; if ({fRvalid, fRdata, fLoad} !== {1'b1, 8'hB1, 5'd3}) begin errCount++; $display("[TB] FAIL b2b_head: got %b/%h/%0d want 1/b1/3", fRvalid, fRdata, fLoad); end
        fRen = 1;
        for (int i = 1; i < 3; i++) begin
            tick();
            checkCount++; if ({fRvalid, fRdata} !== {1'b1, words[i]}) begin errCount++; $display("[TB] FAIL b2b_pop: got %b/%h want 1/%h", fRvalid, fRdata, words[i]); end
            checkCount++; if (fLoad !== 5'(3 - i)) begin errCount++; $display("[TB] FAIL b2b_load: got %0d want %0d", fLoad, 3 - i); end
        end
        tick();
        checkCount++; if ({fRvalid, fLoad, fUnderflow} !== {1'b0, 5'd0, 1'b0}) begin errCount++; $display("[TB] FAIL b2b_last: got %b/%0d/%b want 0/0/0", fRvalid, fLoad, fUnderflow); end
        tick();
        fRen = 0;
        checkCount++; if (fUnderflow !== 1'b1) begin errCount++; $display("[TB] FAIL fwft_underflow: got %b want 1", fUnderflow); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 11; i++) begin
            wWen = 1; wWdata = 8'(i);
            tick();
        end
        checkCount++; if (wLoad !== 5'd11) begin errCount++; $display("[TB] FAIL wrap_prefill: got %0d want 11", wLoad); end
        for (int j = 0; j < 30; j++) begin
            wWen = 1; wRen = 1; wWdata = 8'(12 + j);
            tick();
            checkCount++; if (wRdata !== 8'(j + 1)) begin errCount++; $display("[TB] FAIL wrap_rdata: pair %0d got %h want %h", j, wRdata, 8'(j + 1)); end
            checkCount++; if (wLoad !== 5'd11) begin errCount++; $display("[TB] FAIL wrap_load: pair %0d got %0d want 11", j, wLoad); end
        end
        wRen = 0; wWdata = 8'd42;
        tick();
        checkCount++; if ({wWfull, wAfull, wLoad} !== {2'b11, 5'd12}) begin errCount++; $display("[TB] FAIL wrap_full: got %b/%b/%0d want 1/1/12", wWfull, wAfull, wLoad); end
        wWdata = 8'hFF;
        tick();
        wWen = 0;
        checkCount++; if ({wOverflow, wLoad} !== {1'b1, 5'd12}) begin errCount++; $display("[TB] FAIL wrap_overflow: got %b/%0d want 1/12", wOverflow, wLoad); end
        for (int i = 1; i <= 12; i++) begin
            wRen = 1;
            tick();
            checkCount++; if (wRdata !== 8'(30 + i)) begin errCount++; $display("[TB] FAIL wrap_drain: got %h want %h", wRdata, 8'(30 + i)); end
        end
        wRen = 0;
        checkCount++; if ({wRempty, wLoad} !== {1'b1, 5'd0}) begin errCount++; $display("[TB] FAIL wrap_empty: got %b/%0d want 1/0", wRempty, wLoad); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            sWen = 1; sWdata = 8'h10 + 8'(i);
            tick();
        end
        checkCount++; if (sLoad !== 5'd3) begin errCount++; $display("[TB] FAIL areset_burst: got %0d want 3", sLoad); end
        #3;
        rst_n = 1'b0;
        #1;
        checkCount++; if (sLoad !== 5'd0) begin errCount++; $display("[TB] FAIL areset_load: got %0d want 0", sLoad); end
        checkCount++; if ({sRempty, sAempty, sWfull, sAfull, sRvalid} !== 5'b11000) begin errCount++; $display("[TB] FAIL areset_flags: got %b want 11000", {sRempty, sAempty, sWfull, sAfull, sRvalid}); end
        checkCount++; if (sRdata !== 8'h00) begin errCount++; $display("[TB] FAIL areset_rdata: got %h want 00", sRdata); end
        sWen = 0;
        #2;
        rst_n = 1'b1;
        tick();
        sWen = 1; sWdata = 8'h61;
        tick();
        sWen = 0; sRen = 1;
        tick();
        sRen = 0;
        checkCount++; if ({sRvalid, sRdata, sLoad} !== {1'b1, 8'h61, 5'd0}) begin errCount++; $display("[TB] FAIL areset_resume: got %b/%h/%0d want 1/61/0", sRvalid, sRdata, sLoad); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_clr();
        test_fwft();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
